// File: rtl/sqrt_bus_if.sv
// sqrt_bus_if: memory-mapped front end for the shift/compare square-root core.
// Latches the radicand, pulses the core start, captures the root on the first
// done cycle, and exposes busy/done/timeout status plus the result to software.
//
// Bus handshake: an access happens on any rising clk edge where cs is high
// together with wr (write) or rd (read); there is no wait state. Read data is
// registered and appears on d_out one cycle after the access, and holds until
// the next read.
module sqrt_bus_if #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             rd,
    input  logic             wr,
    input  logic [4:0]       addr,
    input  logic [31:0]      d_in,
    output logic [31:0]      d_out,
    output logic             core_rst,
    output logic             core_init,
    output logic [IN_W-1:0]  core_a,
    input  logic             core_done,
    input  logic [OUT_W-1:0] core_result,
    output logic [1:0]       dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [4:0] ADDR_A      = 5'h04;
    localparam logic [4:0] ADDR_INIT   = 5'h08;
    localparam logic [4:0] ADDR_RESULT = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WD_W-1:0]   r_wd_cnt;
    logic [OUT_W-1:0]  r_result;
    logic              r_done;
    logic              r_timeout;

    logic              w_busy;
    logic              w_wr_a;
    logic              w_start_ok;
    logic              w_wd_hit;
    logic              w_capture;
    logic              w_drain_end;
    logic [31:0]       w_rd_data;
    logic              w_unused_bits;

    assign w_busy      = (r_state != S_IDLE);
    assign w_wr_a      = cs && wr && (addr == ADDR_A) && !w_busy;
    assign w_start_ok  = cs && wr && (addr == ADDR_INIT) && d_in[0] && (r_state == S_IDLE);
    // done has priority over the watchdog when both land on the same cycle
    assign w_wd_hit    = (r_state == S_WAIT) && !core_done && (r_wd_cnt == WD_W'(TIMEOUT));
    assign w_capture   = (r_state == S_WAIT) && core_done;
    assign w_drain_end = (r_state == S_DRAIN) && !core_done;
    assign dbg_state   = r_state;

    // Only d_in[0] and the low radicand bits carry meaning; the rest is ignored.
    assign w_unused_bits = &{1'b0, d_in};

    // Next-state logic for the operation sequencer
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_START;
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (core_done)     w_next = S_DRAIN;
                else if (w_wd_hit) w_next = S_IDLE;
            end
            S_DRAIN: if (!core_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read mux; sampled values are pre-write so a same-cycle write is not seen
    always_comb begin
        w_rd_data = 32'd0;
        case (addr)
            ADDR_RESULT: w_rd_data[OUT_W-1:0] = r_result;
            ADDR_STATUS: w_rd_data[2:0] = {r_timeout, r_done, w_busy};
            default:     w_rd_data = 32'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Core control outputs: start pulse mirrors START, reset pulses on watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_init <= 1'b0;
            core_rst  <= 1'b1;
        end else begin
            core_init <= (w_next == S_START);
            core_rst  <= w_wd_hit;
        end
    end

    // Watchdog counter: cleared in START, counts every WAIT cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     r_wd_cnt <= '0;
        else if (r_state == S_START)  r_wd_cnt <= '0;
        else if (r_state == S_WAIT)   r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end

    // Result capture on the first done cycle (leaving WAIT prevents re-capture)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_result <= '0;
        else if (w_capture) r_result <= core_result;
    end

    // Sticky status bits, both cleared by an accepted INIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_start_ok) begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_drain_end) r_done    <= 1'b1;
            if (w_wd_hit)    r_timeout <= 1'b1;
        end
    end

    // Radicand register, frozen while an operation is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        core_a <= '0;
        else if (w_wr_a) core_a <= d_in[IN_W-1:0];
    end

    // Registered read data, held between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          d_out <= 32'd0;
        else if (cs && rd) d_out <= w_rd_data;
    end

endmodule

// File: tb/tb_sqrt_bus_if.sv
// tb_sqrt_bus_if: directed and randomized checks of the sqrt bus front end,
// with a behavioural square-root core model driving done/result.
module tb_sqrt_bus_if;

    localparam logic [4:0] A_A      = 5'h04;
    localparam logic [4:0] A_INIT   = 5'h08;
    localparam logic [4:0] A_RESULT = 5'h0C;
    localparam logic [4:0] A_STATUS = 5'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, rd, wr;
    logic [4:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        core_rst, core_init;
    logic [15:0] core_a;
    logic        core_done;
    logic [7:0]  core_result;
    logic [1:0]  dbg_state;

    sqrt_bus_if #(.IN_W(16), .OUT_W(8), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
        .d_in(d_in), .d_out(d_out), .core_rst(core_rst), .core_init(core_init),
        .core_a(core_a), .core_done(core_done), .core_result(core_result),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int cyc = 0, init_cnt = 0, init_cyc = 0, rst_cnt = 0, rst_cyc = 0;
    int cm_delay = 20, cm_len = 10;
    bit cm_never = 1'b0;

    // Reference: floor square root by plain search
    function automatic int isqrt(input int a);
        int r = 0;
        while ((r + 1) * (r + 1) <= a) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = 32'd0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = d_out;
    endtask

    task automatic wait_idle(input int max_polls);
        logic [31:0] s;
        int n = 0;
        do begin
            bus_read(A_STATUS, s);
            n++;
        end while (s[0] && n < max_polls);
        chk("wait_idle_bound", {31'd0, s[0]}, 32'd0);
    endtask

    // Full operation with the core model answering after delay/len cycles
    task automatic run_op(input logic [15:0] a, input int dly, input int len);
        logic [31:0] s;
        int i0;
        bus_write(A_A, {16'd0, a});
        cm_delay = dly; cm_len = len; cm_never = 1'b0;
        i0 = init_cnt;
        bus_write(A_INIT, 32'd1);
        bus_read(A_STATUS, s);
        chk("status_busy", s, 32'h1);
        wait_idle(100);
        chk("init_pulse_cycles", init_cnt - i0, 32'd1);
        bus_read(A_STATUS, s);
        chk("status_done", s, 32'h2);
        bus_read(A_RESULT, s);
        chk("result", s, isqrt(int'(a)));
        chk("core_a_held", {16'd0, core_a}, {16'd0, a});
    endtask

    // ---------------- monitor: counts pulse cycles ----------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (core_init) begin init_cnt++; init_cyc = cyc; end
            if (core_rst && rst) begin rst_cnt++; rst_cyc = cyc; end
        end
    end

    // ---------------- behavioural sqrt core ----------------
    initial begin
        logic [15:0] a_l;
        bit aborted;
        core_done = 1'b0;
        core_result = 8'd0;
        forever begin
            @(negedge clk);
            if (core_init && rst && !cm_never) begin
                a_l = core_a;
                aborted = 1'b0;
                for (int i = 0; i < cm_delay; i++) begin
                    @(negedge clk);
                    if (!rst) aborted = 1'b1;
                end
                if (!aborted) begin
                    for (int i = 0; i < cm_len; i++) begin
                        core_done = 1'b1;
                        core_result = (i == 0) ? 8'(isqrt(int'(a_l))) : 8'($urandom);
                        @(negedge clk);
                        if (!rst) break;
                    end
                end
                core_done = 1'b0;
                core_result = 8'($urandom);
            end
        end
    end

    // ---------------- global time limit ----------------
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- stimulus and checks ----------------
    initial begin
        logic [31:0] s;
        logic [15:0] ra;
        int i0, r0;

        rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'd0; d_in = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_core_init", {31'd0, core_init}, 32'd0);
        chk("rst_core_a", {16'd0, core_a}, 32'd0);
        chk("rst_d_out", d_out, 32'd0);
        #1 rst = 1'b1;
        #1 chk("core_rst_held_till_edge", {31'd0, core_rst}, 32'd1);
        @(negedge clk);
        chk("core_rst_released", {31'd0, core_rst}, 32'd0);
        bus_read(A_STATUS, s);
        chk("status_after_reset", s, 32'h0);

        // Unmapped and write-only addresses read zero
        bus_write(5'h14, 32'hDEAD_BEEF);
        bus_read(5'h14, s);
        chk("unmapped_read", s, 32'h0);
        bus_read(A_A, s);
        chk("a_reads_zero", s, 32'h0);

        // 144 -> 12, done after 20 cycles for 10 cycles
        run_op(16'd144, 20, 10);

        // 0xFFFF with a long done window; later result changes ignored
        run_op(16'hFFFF, 5, 40);

        // Radicand 0 and back-to-back INIT
        run_op(16'd0, 3, 1);

        // Writes while busy are ignored
        bus_write(A_A, 32'd200);
        cm_delay = 30; cm_len = 5; cm_never = 1'b0;
        i0 = init_cnt;
        bus_write(A_INIT, 32'd1);
        bus_write(A_A, 32'd81);
        bus_write(A_INIT, 32'd1);
        chk("busy_a_blocked", {16'd0, core_a}, 32'd200);
        wait_idle(100);
        chk("busy_single_init", init_cnt - i0, 32'd1);
        bus_read(A_RESULT, s);
        chk("busy_result", s, 32'd14);

        // Watchdog: core never answers
        cm_never = 1'b1;
        r0 = rst_cnt;
        bus_write(A_INIT, 32'd1);
        wait_idle(200);
        chk("wd_core_rst_cycles", rst_cnt - r0, 32'd1);
        chk("wd_latency", rst_cyc - init_cyc, 32'd257);
        bus_read(A_STATUS, s);
        chk("status_timeout", s, 32'h4);
        cm_never = 1'b0;
        cm_delay = 8; cm_len = 4;
        bus_write(A_INIT, 32'd1);
        bus_read(A_STATUS, s);
        chk("timeout_cleared_restart", s, 32'h1);
        wait_idle(100);
        bus_read(A_STATUS, s);
        chk("restart_done", s, 32'h2);
        bus_read(A_RESULT, s);
        chk("restart_result", s, 32'd14);

        // Randomized radicands and core timing
        for (int k = 0; k < 8; k++) begin
            ra = 16'($urandom_range(0, 65535));
            run_op(ra, $urandom_range(1, 30), $urandom_range(1, 12));
        end

        // Asynchronous reset in the middle of WAIT
        bus_write(A_A, 32'd1000);
        cm_delay = 25; cm_len = 5;
        bus_write(A_INIT, 32'd1);
        bus_read(A_STATUS, s);
        chk("pre_reset_busy", s, 32'h1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_core_rst", {31'd0, core_rst}, 32'd1);
        chk("async_core_init", {31'd0, core_init}, 32'd0);
        chk("async_core_a", {16'd0, core_a}, 32'd0);
        chk("async_d_out", d_out, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        bus_read(A_STATUS, s);
        chk("status_after_async_rst", s, 32'h0);
        bus_read(A_RESULT, s);
        chk("result_after_async_rst", s, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
